// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared state encoding and SRAM timing defaults for the SRAM engines
package sram_ctrl_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_POP   = 3'd1;
  localparam logic [2:0] ST_LATCH = 3'd2;
  localparam logic [2:0] ST_SETUP = 3'd3;
  localparam logic [2:0] ST_PULSE = 3'd4;
  localparam logic [2:0] ST_HOLD  = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    POP   = ST_POP,
    LATCH = ST_LATCH,
    SETUP = ST_SETUP,
    PULSE = ST_PULSE,
    HOLD  = ST_HOLD,
    DONE  = ST_DONE
  } state_t;

  // Timing defaults in clk cycles; the read engine will reuse these.
  localparam int DEFAULT_WE_CYCLES = 2;
  localparam int WE_CYCLES_MAX     = 15;
  localparam int SETUP_CYCLES      = 1;
  localparam int HOLD_CYCLES       = 1;

  // States in which chip enable and the data bus drivers are active.
  function automatic logic drives_bus(state_t s);
    return (s == SETUP) || (s == PULSE) || (s == HOLD);
  endfunction

endpackage

// File: rtl/sram_write_drainer.sv
// rtl/sram_write_drainer.sv - drains FIFO words into an async SRAM at consecutive addresses
module sram_write_drainer
  import sram_ctrl_pkg::*;
#(
  parameter int data_width    = 16,
  parameter int address_width = 18,
  parameter int count_width   = 16,
  parameter int we_cycles     = DEFAULT_WE_CYCLES
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [address_width-1:0] base_address,
  input  logic [count_width-1:0]   word_count,
  output logic                     busy,
  output logic                     done,
  input  logic [data_width-1:0]    fifo_output_data,
  input  logic                     fifo_empty,
  output logic                     fifo_read_enable,
  output logic [address_width-1:0] sram_address,
  output logic [data_width-1:0]    sram_data_out,
  output logic                     sram_data_oe,
  output logic                     sram_ce_n,
  output logic                     sram_we_n,
  output logic                     sram_oe_n
);

  localparam logic [3:0] WAIT_LOAD = 4'(we_cycles - 1);

  state_t                   state;
  state_t                   next_state;
  logic [address_width-1:0] addr_cnt;
  logic [count_width-1:0]   remaining;
  logic [3:0]               wait_cnt;

  assign sram_oe_n = 1'b1;

  always_comb begin
    next_state       = state;
    fifo_read_enable = (state == POP) && !fifo_empty;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = (word_count == '0) ? DONE : POP;
        end
      end
      POP: begin
        if (!fifo_empty) begin
          next_state = LATCH;
        end
      end
      LATCH: next_state = SETUP;
      SETUP: next_state = PULSE;
      PULSE: begin
        if (wait_cnt == 4'd0) begin
          next_state = HOLD;
        end
      end
      HOLD: begin
        next_state = (remaining == count_width'(1)) ? DONE : POP;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // SRAM strobes are decoded from next_state so they come straight off flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      sram_ce_n     <= 1'b1;
      sram_we_n     <= 1'b1;
      sram_data_oe  <= 1'b0;
      sram_address  <= '0;
      sram_data_out <= '0;
      addr_cnt      <= '0;
      remaining     <= '0;
      wait_cnt      <= '0;
    end else begin
      state        <= next_state;
      busy         <= (next_state != IDLE) && (next_state != DONE);
      done         <= (next_state == DONE);
      sram_ce_n    <= !drives_bus(next_state);
      sram_we_n    <= (next_state != PULSE);
      sram_data_oe <= drives_bus(next_state);

      if (state == IDLE && start) begin
        addr_cnt  <= base_address;
        remaining <= word_count;
      end

      if (state == LATCH) begin
        sram_data_out <= fifo_output_data;
      end

      if (next_state == SETUP) begin
        sram_address <= addr_cnt;
      end

      if (state == SETUP) begin
        wait_cnt <= WAIT_LOAD;
      end else if (state == PULSE && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end

      // Counters advance as HOLD ends, so the bus stays stable through HOLD.
      if (state == HOLD) begin
        addr_cnt  <= addr_cnt + address_width'(1);
        remaining <= remaining - count_width'(1);
      end
    end
  end

endmodule

// File: tb/tb_sram_write_drainer.sv
// tb/tb_sram_write_drainer.sv - directed self-checking bench for sram_write_drainer
`timescale 1ns/1ps
module tb_sram_write_drainer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [17:0] base_address;
  logic [15:0] word_count;
  logic        busy;
  logic        done;
  logic [15:0] fifo_output_data;
  logic        fifo_empty;
  logic        fifo_read_enable;
  logic [17:0] sram_address;
  logic [15:0] sram_data_out;
  logic        sram_data_oe;
  logic        sram_ce_n;
  logic        sram_we_n;
  logic        sram_oe_n;

  int tests  = 0;
  int failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    end
  endtask

  sram_write_drainer dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .base_address     (base_address),
    .word_count       (word_count),
    .busy             (busy),
    .done             (done),
    .fifo_output_data (fifo_output_data),
    .fifo_empty       (fifo_empty),
    .fifo_read_enable (fifo_read_enable),
    .sram_address     (sram_address),
    .sram_data_out    (sram_data_out),
    .sram_data_oe     (sram_data_oe),
    .sram_ce_n        (sram_ce_n),
    .sram_we_n        (sram_we_n),
    .sram_oe_n        (sram_oe_n)
  );

  always #5 clk = ~clk;

  // FIFO model: data appears the cycle after a pop.
  logic [15:0] fifo_q[$];
  int          rd_cnt = 0;

  always @(posedge clk) begin
    if (fifo_read_enable && fifo_q.size() > 0) begin
      fifo_output_data <= fifo_q.pop_front();
      fifo_empty       <= (fifo_q.size() == 0);
      rd_cnt           <= rd_cnt + 1;
    end
  end

  // SRAM monitor: one log entry per write-enable low period.
  logic [17:0] wr_addr[$];
  logic [15:0] wr_data[$];
  int          wr_low[$];
  logic        wr_stable[$];
  int          low_cnt   = 0;
  int          total_low = 0;
  int          done_cnt  = 0;
  logic [17:0] cur_addr;
  logic [15:0] cur_data;
  logic        stable;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (!sram_we_n) begin
      total_low++;
      if (low_cnt == 0) begin
        cur_addr = sram_address;
        cur_data = sram_data_out;
        stable   = 1'b1;
      end
      if (sram_address !== cur_addr || sram_data_out !== cur_data ||
          sram_ce_n !== 1'b0 || sram_data_oe !== 1'b1) stable = 1'b0;
      low_cnt++;
    end else if (low_cnt != 0) begin
      wr_addr.push_back(cur_addr);
      wr_data.push_back(cur_data);
      wr_low.push_back(low_cnt);
      wr_stable.push_back(stable);
      low_cnt = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_low.delete();
    wr_stable.delete();
    rd_cnt    = 0;
    total_low = 0;
    done_cnt  = 0;
  endtask

  task automatic do_start(input logic [17:0] b, input logic [15:0] c);
    start        = 1'b1;
    base_address = b;
    word_count   = c;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int from, output int n);
    n = from;
    while (!done && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic check_write(input int i, input logic [17:0] a, input logic [15:0] d);
    if (wr_addr.size() > i) begin
      check($sformatf("wr%0d_addr", i), wr_addr[i], a);
      check($sformatf("wr%0d_data", i), wr_data[i], d);
      check($sformatf("wr%0d_we_low", i), wr_low[i], 2);
      check($sformatf("wr%0d_stable", i), wr_stable[i], 1'b1);
    end else begin
      check($sformatf("wr%0d_present", i), wr_addr.size(), i + 1);
    end
  endtask

  initial begin
    int n;
    reset            = 1'b1;
    start            = 1'b0;
    base_address     = '0;
    word_count       = '0;
    fifo_empty       = 1'b1;
    fifo_output_data = '0;
    tick(); tick(); tick();

    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_fre", fifo_read_enable, 1'b0);
    check("rst_ce_n", sram_ce_n, 1'b1);
    check("rst_we_n", sram_we_n, 1'b1);
    check("rst_oe_n", sram_oe_n, 1'b1);
    check("rst_data_oe", sram_data_oe, 1'b0);
    check("rst_addr", sram_address, 18'h0);
    check("rst_data", sram_data_out, 16'h0);
    reset = 1'b0;
    tick();
    clear_log();

    // Three back-to-back words
    push(16'hA001); push(16'hA002); push(16'hA003);
    do_start(18'h00010, 16'd3);
    check("t1_busy_rise", busy, 1'b1);
    wait_done(0, n);
    check("t1_latency", n, 18);
    check("t1_busy_at_done", busy, 1'b0);
    tick();
    check("t1_done_one_cycle", done, 1'b0);
    check("t1_busy_after", busy, 1'b0);
    check("t1_nwrites", wr_addr.size(), 3);
    check_write(0, 18'h00010, 16'hA001);
    check_write(1, 18'h00011, 16'hA002);
    check_write(2, 18'h00012, 16'hA003);
    check("t1_addr_hold", sram_address, 18'h00012);
    check("t1_data_hold", sram_data_out, 16'hA003);
    check("t1_oe_n", sram_oe_n, 1'b1);
    clear_log();

    // Zero-length job
    do_start(18'h00020, 16'd0);
    check("t2_done", done, 1'b1);
    check("t2_busy", busy, 1'b0);
    tick(); tick(); tick();
    check("t2_done_drop", done, 1'b0);
    check("t2_no_pop", rd_cnt, 0);
    check("t2_no_we", total_low, 0);
    clear_log();

    // Empty-FIFO stall: second word arrives 10 clk after start
    push(16'hB001);
    do_start(18'h00100, 16'd2);
    for (int i = 0; i < 8; i++) tick();
    check("t3_stall_busy", busy, 1'b1);
    check("t3_stall_ce_n", sram_ce_n, 1'b1);
    check("t3_stall_we_n", sram_we_n, 1'b1);
    check("t3_stall_fre", fifo_read_enable, 1'b0);
    tick(); tick();
    push(16'hB002);
    wait_done(10, n);
    check("t3_latency", n, 16);
    tick();
    check("t3_nwrites", wr_addr.size(), 2);
    check_write(0, 18'h00100, 16'hB001);
    check_write(1, 18'h00101, 16'hB002);
    clear_log();

    // Address wrap
    push(16'hC001); push(16'hC002);
    do_start(18'h3FFFF, 16'd2);
    wait_done(0, n);
    check("t4_latency", n, 12);
    tick();
    check("t4_nwrites", wr_addr.size(), 2);
    check_write(0, 18'h3FFFF, 16'hC001);
    check_write(1, 18'h00000, 16'hC002);
    clear_log();

    // Reset during the write pulse of word 2 of 4
    push(16'hD001); push(16'hD002); push(16'hD003); push(16'hD004);
    do_start(18'h00200, 16'd4);
    for (int i = 0; i < 9; i++) tick();
    check("t5_in_pulse", sram_we_n, 1'b0);
    check("t5_pulse_addr", sram_address, 18'h00201);
    reset = 1'b1;
    tick();
    check("t5_we_n", sram_we_n, 1'b1);
    check("t5_ce_n", sram_ce_n, 1'b1);
    check("t5_data_oe", sram_data_oe, 1'b0);
    check("t5_busy", busy, 1'b0);
    reset = 1'b0;
    tick();
    check("t5_fifo_left", fifo_q.size(), 2);
    clear_log();
    do_start(18'h00300, 16'd2);
    wait_done(0, n);
    check("t5_restart_latency", n, 12);
    tick();
    check("t5_nwrites", wr_addr.size(), 2);
    check_write(0, 18'h00300, 16'hD003);
    check_write(1, 18'h00301, 16'hD004);
    clear_log();

    // Second start mid-job is dropped
    push(16'hE001); push(16'hE002);
    do_start(18'h00400, 16'd2);
    tick(); tick(); tick();
    start        = 1'b1;
    base_address = 18'h00500;
    word_count   = 16'd5;
    tick();
    start = 1'b0;
    wait_done(4, n);
    check("t6_latency", n, 12);
    for (int i = 0; i < 6; i++) tick();
    check("t6_done_count", done_cnt, 1);
    check("t6_busy", busy, 1'b0);
    check("t6_nwrites", wr_addr.size(), 2);
    check_write(0, 18'h00400, 16'hE001);
    check_write(1, 18'h00401, 16'hE002);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/sram_write_drainer.md
Name: sram_write_drainer

Overview:
Single-clock write engine that sits directly downstream of the write-buffer FIFO. It pops data words from the FIFO read port and writes each one to an asynchronous SRAM at consecutive addresses. A job is started with a base address and a word count. The SRAM write pulse width is set by a parameter.

Parameters:
data_width, 16, FIFO word width and SRAM data bus width
address_width, 18, SRAM address width
count_width, 16, width of the word_count job length
we_cycles, 2, write-enable low time in clk cycles; legal range 1..15

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle job request; ignored while busy=1
base_address  input  address_width  first SRAM address, sampled when start is accepted
word_count  input  count_width  number of words to write, sampled when start is accepted
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when the job completes
fifo_output_data  input  data_width  FIFO read data; valid the cycle after a pop
fifo_empty  input  1  FIFO empty flag
fifo_read_enable  output  1  pop request to the FIFO
sram_address  output  address_width  SRAM address
sram_data_out  output  data_width  SRAM write data
sram_data_oe  output  1  tristate enable for sram_data_out
sram_ce_n  output  1  SRAM chip enable, active low
sram_we_n  output  1  SRAM write enable, active low
sram_oe_n  output  1  SRAM output enable; held at 1

Behaviour:
- Reset values: busy=0, done=0, fifo_read_enable=0, sram_ce_n=1, sram_we_n=1, sram_oe_n=1, sram_data_oe=0, sram_address=0, sram_data_out=0. The FSM returns to IDLE.
- Reset mid-job aborts immediately. On the next edge all SRAM controls are inactive. The popped-but-unwritten word is lost. Remaining words stay in the FIFO.
- States: IDLE, POP, LATCH, SETUP, PULSE, HOLD, DONE.
- IDLE:
  - start=1 loads the address counter from base_address and the remaining counter from word_count.
  - Goes to POP, or to DONE if word_count=0.
- POP:
  - fifo_read_enable = (state==POP) && !fifo_empty. This is the only combinational output.
  - Stays in POP while fifo_empty=1; no SRAM activity during the stall.
  - Goes to LATCH on a pop.
- LATCH: captures fifo_output_data into the data register. Goes to SETUP.
- SETUP (1 cycle):
  - sram_ce_n=0, sram_we_n=1, sram_data_oe=1.
  - sram_address is the counter value; sram_data_out is the data register.
- PULSE: sram_we_n=0 for exactly we_cycles cycles, with address and data stable.
- HOLD (1 cycle):
  - sram_we_n=1, ce_n=0, data still driven.
  - Address counter increments; remaining counter decrements.
  - Goes to DONE if remaining becomes 0, else back to POP.
- DONE: done=1 for one cycle, busy drops, and all SRAM controls go inactive. Returns to IDLE.
- Output timing: SRAM-side outputs are registered and decoded from the next state, so they are glitch-free.
- Throughput: 4+we_cycles clk per word when the FIFO is never empty (6 clk at default).
- Address counter wraps modulo 2^address_width, with no error flag.
- A start pulse in DONE or any busy state is dropped, not queued.
- sram_address and sram_data_out hold their last values when idle.

Decomposition:
- Shared package sram_ctrl_pkg holds:
  - state encoding localparams (3-bit);
  - SRAM timing constant defaults, shared with the future read engine.
- The we_cycles wait counter (4-bit) stays inline; no sub-module is needed.

Test Plan:
- Reset, then start with base=0x00010, count=3, FIFO preloaded with 0xA001,0xA002,0xA003. Required:
  - three writes to 0x00010..0x00012 with matching data;
  - sram_we_n low exactly 2 clk per word;
  - done pulse 18 clk after busy rises;
  - busy=0 afterwards.
- Start with count=0 → done pulses one cycle after acceptance, no fifo_read_enable and no sram_we_n activity.
- Empty-FIFO stall: count=2 with one word present; push the second word 10 clk later. Required: FSM holds in POP with SRAM idle, then completes both writes. Total job time is 12 plus the stall.
- Wrap: base=0x3FFFF, count=2 → writes to 0x3FFFF, then 0x00000.
- Assert reset during PULSE of word 2 of 4 → next edge sram_we_n=1, ce_n=1, data_oe=0, busy=0. A subsequent start works normally.
- Start pulsed again mid-job → ignored: word count and addresses are unchanged and only one done pulse occurs.
